// File: rtl/mdu_ctrl_if.sv
// MDU issue/result bundle between the E stage and mdu_ctrl.
// master drives issue and D-stage info; slave returns status and HI/LO.
interface mdu_ctrl_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_md;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rs_val, rt_val, d_md,
    input  busy, stall_req, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, d_md,
    output busy, stall_req, hi, lo
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide unit controller with HI/LO registers.
// Optional accumulate ops (madd/msub family) enabled by MDU_MADD_EN.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  mdu_ctrl_if.slave bus
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [3:0]  r_op;
  logic [31:0] r_rs;
  logic [31:0] r_rt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  state_t      w_state_nx;
  logic [3:0]  w_cnt_nx;
  logic [31:0] w_hi_nx;
  logic [31:0] w_lo_nx;
  logic        w_ld;

  logic        w_mul;
  logic        w_div;
  logic        w_mthi;
  logic        w_mtlo;

  logic        w_sgn;
  logic        w_is_div;
  logic [63:0] w_a;
  logic [63:0] w_b;
  logic [63:0] w_prod;
  logic        w_rs_neg;
  logic        w_rt_neg;
  logic [31:0] w_na;
  logic [31:0] w_nb;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic [63:0] w_res;
  logic        w_wr;

  // Issue decode; only meaningful while IDLE.
  always_comb begin
    w_mul  = bus.start & (bus.op == 4'd0 | bus.op == 4'd1);
`ifdef MDU_MADD_EN
    w_mul  = w_mul | (bus.start & (bus.op[3:2] == 2'b10));
`endif
    w_div  = bus.start & (bus.op == 4'd2 | bus.op == 4'd3);
    w_mthi = bus.start & (bus.op == 4'd4);
    w_mtlo = bus.start & (bus.op == 4'd5);
  end

  // Result datapath from latched operands; even opcodes are signed.
  always_comb begin
    w_sgn    = ~r_op[0];
    w_is_div = (r_op[3:1] == 3'b001);
    w_a      = {{32{w_sgn & r_rs[31]}}, r_rs};
    w_b      = {{32{w_sgn & r_rt[31]}}, r_rt};
    w_prod   = w_a * w_b;
    w_rs_neg = w_sgn & r_rs[31];
    w_rt_neg = w_sgn & r_rt[31];
    w_na     = w_rs_neg ? (32'd0 - r_rs) : r_rs;
    w_nb     = w_rt_neg ? (32'd0 - r_rt) : r_rt;
    if (r_rt == 32'd0)
      w_nb   = 32'd1;
    w_uq     = w_na / w_nb;
    w_ur     = w_na % w_nb;
    w_res    = w_prod;
`ifdef MDU_MADD_EN
    if (r_op[3])
      w_res  = r_op[1] ? ({r_hi, r_lo} - w_prod)
                       : ({r_hi, r_lo} + w_prod);
`endif
    if (w_is_div) begin
      w_res[31:0]  = (w_rs_neg ^ w_rt_neg) ? (32'd0 - w_uq) : w_uq;
      w_res[63:32] = w_rs_neg ? (32'd0 - w_ur) : w_ur;
    end
    w_wr     = ~w_is_div | (r_rt != 32'd0);
  end

  // Next state, counter and HI/LO update.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_hi_nx    = r_hi;
    w_lo_nx    = r_lo;
    w_ld       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        unique case (1'b1)
          w_mul: begin
            w_ld       = 1'b1;
            w_cnt_nx   = 4'(MULT_CYCLES);
            w_state_nx = S_BUSY;
          end
          w_div: begin
            w_ld       = 1'b1;
            w_cnt_nx   = 4'(DIV_CYCLES);
            w_state_nx = S_BUSY;
          end
          w_mthi:  w_hi_nx = bus.rs_val;
          w_mtlo:  w_lo_nx = bus.rs_val;
          default: ;
        endcase
      end
      S_BUSY: begin
        w_cnt_nx = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_nx = S_IDLE;
          if (w_wr) begin
            w_hi_nx = w_res[63:32];
            w_lo_nx = w_res[31:0];
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // State and architectural registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_op    <= 4'd0;
      r_rs    <= 32'd0;
      r_rt    <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_hi    <= w_hi_nx;
      r_lo    <= w_lo_nx;
      if (w_ld) begin
        r_op <= bus.op;
        r_rs <= bus.rs_val;
        r_rt <= bus.rt_val;
      end
    end
  end

  assign bus.busy      = (r_state == S_BUSY);
  assign bus.stall_req = bus.d_md & (bus.start | bus.busy);
  assign bus.hi        = r_hi;
  assign bus.lo        = r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed table, corner sequences,
// and randomized traffic against a behavioural HI/LO model.
module tb_mdu_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;

  mdu_ctrl_if bus();

  mdu_ctrl #(
    .MULT_CYCLES(MC),
    .DIV_CYCLES (DC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          cyc;
  } vec_t;

  vec_t vt[11];

  // model state
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  int          m_rem;
  logic        m_wr;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    bus.start  = 1'b0;
    bus.op     = 4'd0;
    bus.rs_val = 32'd0;
    bus.rt_val = 32'd0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] rs,
                       input logic [31:0] rt);
    bus.start  = 1'b1;
    bus.op     = op;
    bus.rs_val = rs;
    bus.rt_val = rt;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    idle_in();
    tick();
    reset = 1'b0;
  endtask

  // Counts busy cycles (bounded) and checks HI/LO hold meanwhile.
  task automatic wait_busy(input string nm, input logic [31:0] h,
                           input logic [31:0] l, output int n);
    logic held;
    held = 1'b1;
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      if (bus.hi !== h || bus.lo !== l) held = 1'b0;
      n++;
      tick();
    end
    chk({nm, " hold"}, {63'd0, held}, 64'd1);
  endtask

  // Behavioural model: one clock edge with the given inputs.
  task automatic mdl_step(input logic rst, input logic st,
                          input logic [3:0] op, input logic [31:0] rs,
                          input logic [31:0] rt);
    longint a, b, q, r;
    logic [63:0] p, acc;
    int si, ti;
    si = rs;
    ti = rt;
    if (op[0]) begin
      a = longint'({32'd0, rs});
      b = longint'({32'd0, rt});
    end else begin
      a = si;
      b = ti;
    end
    if (rst) begin
      m_hi = 0; m_lo = 0; m_rem = 0; m_wr = 0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0 && m_wr) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (st) begin
      case (op)
        4'd0, 4'd1: begin
          p = a * b;
          {m_phi, m_plo} = p;
          m_wr = 1; m_rem = MC;
        end
        4'd2, 4'd3: begin
          m_rem = DC;
          m_wr  = (rt != 0);
          if (rt != 0) begin
            q = a / b;
            r = a % b;
            m_plo = q[31:0];
            m_phi = r[31:0];
          end
        end
        4'd4: m_hi = rs;
        4'd5: m_lo = rs;
`ifdef MDU_MADD_EN
        4'd8, 4'd9, 4'd10, 4'd11: begin
          p = a * b;
          acc = {m_hi, m_lo};
          {m_phi, m_plo} = op[1] ? acc - p : acc + p;
          m_wr = 1; m_rem = MC;
        end
`endif
        default: ;
      endcase
    end
  endtask

  initial begin
    int n;
    logic rst_r, st_r;
    logic [3:0] op_r;
    logic [31:0] rs_r, rt_r;
    n_chk  = 0;
    n_pass = 0;
    bus.d_md = 1'b0;
    reset = 1'b0;
    idle_in();

    vt[0]  = '{4'd0, 32'hFFFFFFFE, 32'd3, 0, 0,
               32'hFFFFFFFF, 32'hFFFFFFFA, MC};
    vt[1]  = '{4'd1, 32'hFFFFFFFE, 32'd3, 0, 0,
               32'h2, 32'hFFFFFFFA, MC};
    vt[2]  = '{4'd0, 32'hFFFFFFFD, 32'hFFFFFFFB, 7, 7,
               32'h0, 32'd15, MC};
    vt[3]  = '{4'd3, 32'd100, 32'd7, 0, 0, 32'd2, 32'd14, DC};
    vt[4]  = '{4'd2, 32'hFFFFFFF9, 32'd2, 0, 0,
               32'hFFFFFFFF, 32'hFFFFFFFD, DC};
    vt[5]  = '{4'd2, 32'h80000000, 32'hFFFFFFFF, 5, 5,
               32'h0, 32'h80000000, DC};
    vt[6]  = '{4'd2, 32'd9, 32'd0, 32'hAA, 32'hBB,
               32'hAA, 32'hBB, DC};
    vt[7]  = '{4'd3, 32'd9, 32'd0, 32'h11, 32'h22,
               32'h11, 32'h22, DC};
`ifdef MDU_MADD_EN
    vt[8]  = '{4'd9, 32'd1, 32'd1, 0, 32'hFFFFFFFF,
               32'd1, 32'd0, MC};
`else
    vt[8]  = '{4'd9, 32'd1, 32'd1, 0, 32'hFFFFFFFF,
               32'd0, 32'hFFFFFFFF, 0};
`endif
    vt[9]  = '{4'd7, 32'd1, 32'd1, 32'h33, 32'h44,
               32'h33, 32'h44, 0};
    vt[10] = '{4'd2, 32'd7, 32'hFFFFFFFE, 0, 0,
               32'd1, 32'hFFFFFFFD, DC};

    tick();
    do_reset();
    chk("rst busy", {63'd0, bus.busy}, 64'd0);
    chk("rst hi", {32'd0, bus.hi}, 64'd0);
    chk("rst lo", {32'd0, bus.lo}, 64'd0);

    for (int i = 0; i < 11; i++) begin
      issue(4'd4, vt[i].pre_hi, 0);
      tick();
      issue(4'd5, vt[i].pre_lo, 0);
      tick();
      issue(vt[i].op, vt[i].rs, vt[i].rt);
      tick();
      idle_in();
      wait_busy($sformatf("v%0d", i), vt[i].pre_hi, vt[i].pre_lo, n);
      chk($sformatf("v%0d cycles", i), 64'(n), 64'(vt[i].cyc));
      chk($sformatf("v%0d hi", i), {32'd0, bus.hi}, {32'd0, vt[i].exp_hi});
      chk($sformatf("v%0d lo", i), {32'd0, bus.lo}, {32'd0, vt[i].exp_lo});
    end

    // mthi during BUSY ignored; stall follows busy with d_md high
    do_reset();
    bus.d_md = 1'b1;
    issue(4'd0, 32'hFFFFFFFE, 32'd3);
    #1;
    chk("s34 stall c0", {63'd0, bus.stall_req}, 64'd1);
    tick();
    for (int c = 1; c <= 5; c++) begin
      if (c == 2) issue(4'd4, 32'h1234, 0);
      else idle_in();
      #1;
      chk($sformatf("s34 stall c%0d", c), {63'd0, bus.stall_req}, 64'd1);
      chk($sformatf("s34 busy c%0d", c), {63'd0, bus.busy}, 64'd1);
      tick();
    end
    idle_in();
    #1;
    chk("s34 stall c6", {63'd0, bus.stall_req}, 64'd0);
    chk("s34 hi", {32'd0, bus.hi}, 64'hFFFFFFFF);
    chk("s34 lo", {32'd0, bus.lo}, 64'hFFFFFFFA);
    bus.d_md = 1'b0;

    // back-to-back issue on the first IDLE cycle
    issue(4'd0, 32'd2, 32'd3);
    tick();
    idle_in();
    wait_busy("b2b m", 32'hFFFFFFFF, 32'hFFFFFFFA, n);
    chk("b2b m cycles", 64'(n), 64'(MC));
    issue(4'd3, 32'd100, 32'd7);
    tick();
    idle_in();
    chk("b2b d busy", {63'd0, bus.busy}, 64'd1);
    wait_busy("b2b d", 32'd0, 32'd6, n);
    chk("b2b d cycles", 64'(n), 64'(DC));
    chk("b2b d lo", {32'd0, bus.lo}, 64'd14);

    // reset aborts divu in progress
    issue(4'd3, 32'd100, 32'd7);
    tick();
    idle_in();
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort busy", {63'd0, bus.busy}, 64'd0);
    chk("abort hilo", {bus.hi, bus.lo}, 64'd0);
    for (int c = 0; c < 12; c++) tick();
    chk("abort late", {bus.hi, bus.lo}, 64'd0);

    // reset beats start in the same cycle
    reset = 1'b1;
    issue(4'd4, 32'h5555, 0);
    tick();
    reset = 1'b0;
    idle_in();
    chk("rst prio hi", {32'd0, bus.hi}, 64'd0);

    // randomized traffic vs model
    do_reset();
    mdl_step(1'b1, 1'b0, 4'd0, 0, 0);
    for (int c = 0; c < 600; c++) begin
      chk("rnd busy", {63'd0, bus.busy}, {63'd0, m_rem > 0});
      chk("rnd hilo", {bus.hi, bus.lo}, {m_hi, m_lo});
      rst_r = ($urandom_range(63) == 0);
      st_r  = ($urandom_range(2) != 0);
      op_r  = ($urandom_range(3) == 0) ? 4'($urandom_range(15))
                                       : 4'($urandom_range(5));
      rs_r  = ($urandom_range(7) == 0) ? 32'h80000000 : $urandom;
      rt_r  = ($urandom_range(5) == 0) ? 32'd0 :
              ($urandom_range(5) == 0) ? 32'hFFFFFFFF : $urandom;
      reset      = rst_r;
      bus.start  = st_r;
      bus.op     = op_r;
      bus.rs_val = rs_r;
      bus.rt_val = rt_r;
      bus.d_md   = $urandom_range(1);
      #1;
      chk("rnd stall", {63'd0, bus.stall_req},
          {63'd0, bus.d_md & (st_r | (m_rem > 0))});
      mdl_step(rst_r, st_r, op_r, rs_r, rt_r);
      tick();
    end
    reset = 1'b0;
    idle_in();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter: MULT_CYCLES, default 5, busy cycles for mult/multu (legal 1..15).
REQ-002 Parameter: DIV_CYCLES, default 10, busy cycles for div/divu (legal 1..15).
REQ-003 Port: clk  input  1  rising-edge clock; sole clock.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  E-stage MDU instruction valid this cycle.
REQ-006 Port: op  input  4  operation: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 8 madd, 9 maddu, 10 msub, 11 msubu; others = no-op.
REQ-007 Port: rs_val  input  32  forwarded rs operand.
REQ-008 Port: rt_val  input  32  forwarded rt operand.
REQ-009 Port: d_md  input  1  D-stage instruction is any MDU op or mfhi/mflo.
REQ-010 Port: busy  output  1  unit computing.
REQ-011 Port: stall_req  output  1  request to the hazard unit to freeze F/D and bubble E.
REQ-012 Port: hi  output  32  architectural HI.
REQ-013 Port: lo  output  32  architectural LO.

Function
REQ-014 Two states, IDLE and BUSY; busy SHALL be 1 exactly in BUSY.
REQ-015 IDLE + start + compute op (mult/div/madd class) sampled at edge of cycle T: latch operands and result, load counter with N (MULT_CYCLES for mult/madd class, DIV_CYCLES for div class), enter BUSY; busy=1 in cycles T+1..T+N.
REQ-016 Counter decrements each BUSY cycle; at edge ending cycle T+N, HI/LO SHALL take the result and state returns to IDLE; new values visible from cycle T+N+1.
REQ-017 HI/LO SHALL hold prior values throughout BUSY.
REQ-018 IDLE + start + mthi/mtlo: HI (resp. LO) := rs_val at next edge; no BUSY entry.
REQ-019 start while BUSY SHALL be ignored entirely (no operand latch, no HI/LO write, counter unaffected).
REQ-020 start with no-op code SHALL change no state.
REQ-021 mult: {HI,LO} = signed 64-bit product; multu: unsigned product.
REQ-022 div/divu: LO = quotient truncated toward zero, HI = remainder with sign of dividend (rs_val / rt_val).
REQ-023 div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000.
REQ-024 rt_val=0 for div/divu: full DIV_CYCLES busy, HI/LO unchanged at completion.
REQ-025 stall_req = d_md & (start | busy), combinational, so a D-stage MDU/mf instruction waits until the unit is IDLE with no issue in E.
REQ-026 Back-to-back: start in the cycle state returns to IDLE (T+N+1) SHALL be accepted normally.

Reset
REQ-027 On reset at an edge: state IDLE, counter 0, busy=0, hi=0, lo=0, latched operands 0.
REQ-028 Reset during BUSY SHALL abort the operation; no HI/LO write occurs.
REQ-029 Reset SHALL take priority over start in the same cycle.

Configuration
REQ-030 Macro MDU_MADD_EN: when defined, ops 8-11 SHALL start a MULT_CYCLES operation computing {HI,LO} +/- product (madd/msub signed, maddu/msubu unsigned, 64-bit wrap) using {HI,LO} sampled at issue.
REQ-031 Without MDU_MADD_EN, ops 8-11 SHALL be no-ops per REQ-020 and no accumulate logic shall be present.

Verification
REQ-032 mult rs=0xFFFFFFFE, rt=0x00000003 at cycle 0 -> busy cycles 1-5, hi=0xFFFFFFFF, lo=0xFFFFFFFA from cycle 6.
REQ-033 divu rs=100, rt=7 -> busy cycles 1-10, lo=14, hi=2 from cycle 11; div rs=-7, rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-034 mult issued, then start mthi rs=0x1234 in cycle 2 -> ignored; hi = product at cycle 6; stall_req=1 in cycles 1-5 when d_md=1, 0 in cycle 6.
REQ-035 divu in progress, reset at cycle 4 -> busy=0, hi=lo=0 from cycle 5; no later write.
REQ-036 div rt=0 with hi=0xAA, lo=0xBB -> busy 10 cycles, hi=0xAA, lo=0xBB after.
REQ-037 MDU_MADD_EN defined, hi=0, lo=0xFFFFFFFF, maddu rs=1, rt=1 -> hi=1, lo=0 after 5 busy cycles; undefined -> no busy, hi/lo unchanged.
